// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default parameter values for the reset release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RELEASE  = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } rst_seq_state_t;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_SYNC_DEPTH  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_DEPTH clock edges.
module reset_sync #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [SYNC_DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_rst_n = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases NUM_STAGES reset domains one at a time, each waiting for the previous ack.
// Optional ack timeout enabled by defining RST_SEQ_ACK_TIMEOUT_EN.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int SYNC_DEPTH  = DEF_SYNC_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  busy,
  output logic                  all_released,
  output logic                  err_timeout
);

  localparam int CNT_MAX = max_int(HOLD_CYCLES, ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int K_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [K_W-1:0]   LAST_K    = K_W'(NUM_STAGES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic           sync_rst_n;
  rst_seq_state_t state;
  logic [K_W-1:0] k;
  logic [CNT_W-1:0] hold_cnt;
  logic           timed_out;

  // Internal reset only ever deasserts through the synchronizer.
  reset_sync #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n)
  );

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] to_cnt;

  assign timed_out = (state == ST_WAIT_ACK) && !stage_ack[k] && (to_cnt >= TO_LAST);

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_WAIT_ACK) to_cnt <= sat_inc(to_cnt);
      else                      to_cnt <= '0;
      if (state == ST_DONE && sw_req) err_timeout <= 1'b0;
      else if (timed_out)             err_timeout <= 1'b1;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state        <= ST_HOLD;
      k            <= '0;
      hold_cnt     <= '0;
      stage_rst_n  <= '0;
      busy         <= 1'b1;
      all_released <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt >= HOLD_LAST) begin
            state    <= ST_RELEASE;
            k        <= '0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        ST_RELEASE: begin
          stage_rst_n[k] <= 1'b1;
          state          <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // A timeout is treated exactly like an ack so the sequence never stalls.
          if (stage_ack[k] || timed_out) begin
            if (k == LAST_K) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              all_released <= 1'b1;
            end else begin
              k     <= k + 1'b1;
              state <= ST_RELEASE;
            end
          end
        end
        ST_DONE: begin
          if (sw_req) begin
            state        <= ST_HOLD;
            k            <= '0;
            hold_cnt     <= '0;
            stage_rst_n  <= '0;
            busy         <= 1'b1;
            all_released <= 1'b0;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with default parameters.
module tb_reset_release_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw_req;
  logic [3:0] stage_ack;
  logic [3:0] stage_rst_n;
  logic       busy;
  logic       all_released;
  logic       err_timeout;

  logic [3:0] ack_en;
  logic [3:0] ack_force;

  int vectors;
  int miscompares;

  reset_release_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_req       (sw_req),
    .stage_ack    (stage_ack),
    .stage_rst_n  (stage_rst_n),
    .busy         (busy),
    .all_released (all_released),
    .err_timeout  (err_timeout)
  );

  // Stages acknowledge as soon as they see their reset released (if enabled).
  assign stage_ack = (stage_rst_n & ack_en) | ack_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    sw_req      = 1'b0;
    ack_en      = 4'hF;
    ack_force   = 4'h0;

    // Reset state
    tick(2);
    chk("rst_stage", 32'(stage_rst_n), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_all", 32'(all_released), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // Power-on: stage0 at edge 20, then every 2 edges, done at edge 27
    rst_n = 1'b1;
    tick(19);
    chk("po_e19_stage", 32'(stage_rst_n), 32'h0);
    tick(1);
    chk("po_e20_stage", 32'(stage_rst_n), 32'h1);
    tick(1);
    chk("po_e21_stage", 32'(stage_rst_n), 32'h1);
    tick(1);
    chk("po_e22_stage", 32'(stage_rst_n), 32'h3);
    tick(2);
    chk("po_e24_stage", 32'(stage_rst_n), 32'h7);
    tick(2);
    chk("po_e26_stage", 32'(stage_rst_n), 32'hF);
    chk("po_e26_all", 32'(all_released), 32'h0);
    chk("po_e26_busy", 32'(busy), 32'h1);
    tick(1);
    chk("po_e27_all", 32'(all_released), 32'h1);
    chk("po_e27_busy", 32'(busy), 32'h0);

    // sw_req in DONE restarts with no sync delay; sw_req in HOLD and early ack[3] are ignored
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    chk("sw_stage", 32'(stage_rst_n), 32'h0);
    chk("sw_all", 32'(all_released), 32'h0);
    chk("sw_busy", 32'(busy), 32'h1);
    chk("sw_err", 32'(err_timeout), 32'h0);
    tick(2);
    sw_req    = 1'b1;
    ack_force = 4'b1000;
    tick(1);
    sw_req = 1'b0;
    tick(13);
    chk("sw_e16_stage", 32'(stage_rst_n), 32'h0);
    tick(1);
    chk("sw_e17_stage", 32'(stage_rst_n), 32'h1);
    tick(2);
    chk("sw_e19_order", 32'(stage_rst_n), 32'h3);
    tick(2);
    chk("sw_e21_order", 32'(stage_rst_n), 32'h7);
    tick(2);
    chk("sw_e23_stage", 32'(stage_rst_n), 32'hF);
    tick(1);
    chk("sw_e24_all", 32'(all_released), 32'h1);
    tick(3);
    chk("sw_stays_done", 32'(all_released), 32'h1);
    chk("sw_stays_stage", 32'(stage_rst_n), 32'hF);
    ack_force = 4'h0;

    // Stage 2 never acks
    ack_en = 4'b1011;
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    chk("to_start_stage", 32'(stage_rst_n), 32'h0);
    tick(17);
    chk("to_e17_stage", 32'(stage_rst_n), 32'h1);
    tick(4);
    chk("to_e21_stage", 32'(stage_rst_n), 32'h7);
    tick(63);
    chk("to_e84_stage", 32'(stage_rst_n), 32'h7);
    chk("to_e84_err", 32'(err_timeout), 32'h0);
    tick(1);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    chk("to_e85_err", 32'(err_timeout), 32'h1);
    chk("to_e85_stage", 32'(stage_rst_n), 32'h7);
    tick(1);
    chk("to_e86_stage", 32'(stage_rst_n), 32'hF);
    tick(1);
    chk("to_e87_all", 32'(all_released), 32'h1);
    chk("to_e87_err", 32'(err_timeout), 32'h1);
`else
    chk("wait_e85_err", 32'(err_timeout), 32'h0);
    chk("wait_e85_stage", 32'(stage_rst_n), 32'h7);
    tick(40);
    chk("wait_long_stage", 32'(stage_rst_n), 32'h7);
    chk("wait_long_busy", 32'(busy), 32'h1);
    ack_en = 4'hF;
    tick(2);
    chk("wait_ack_stage", 32'(stage_rst_n), 32'hF);
    tick(1);
    chk("wait_ack_all", 32'(all_released), 32'h1);
`endif

    // Restart clears the sticky error; then stall stage 1 and assert rst_n mid-wait
    ack_en = 4'b0001;
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    chk("clr_err", 32'(err_timeout), 32'h0);
    chk("clr_stage", 32'(stage_rst_n), 32'h0);
    tick(17);
    chk("ab_e17_stage", 32'(stage_rst_n), 32'h1);
    tick(2);
    chk("ab_e19_stage", 32'(stage_rst_n), 32'h3);
    tick(3);
    chk("ab_wait_stage", 32'(stage_rst_n), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ab_async_stage", 32'(stage_rst_n), 32'h0);
    chk("ab_async_busy", 32'(busy), 32'h1);
    chk("ab_async_all", 32'(all_released), 32'h0);
    tick(2);
    rst_n  = 1'b1;
    ack_en = 4'hF;
    tick(19);
    chk("rs_e19_stage", 32'(stage_rst_n), 32'h0);
    tick(1);
    chk("rs_e20_stage", 32'(stage_rst_n), 32'h1);
    tick(6);
    chk("rs_e26_stage", 32'(stage_rst_n), 32'hF);
    tick(1);
    chk("rs_e27_all", 32'(all_released), 32'h1);
    chk("rs_e27_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
